// File: rtl/divide_f32_restoring.sv
// Sequential IEEE-754 single-precision divider: one restoring quotient bit per clock.
// Fixed latency of 27 clocks for normal operands and 1 clock for specials; result holds until rst.
module divide_f32_restoring (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] num,
  input  logic [31:0] den,
  output logic        rdy,
  output logic [31:0] quo
);
  // state  | meaning
  // LOAD   | capture operands, resolve specials
  // DIVIDE | 25 restoring iterations, one quotient bit each
  // NORM   | normalise, compute exponent, flush or saturate
  // DONE   | hold quo/rdy until the next rst
  localparam int WIDTH         = 32;
  localparam int EXPONENTWIDTH = 8;
  localparam int MANTISSAWIDTH = 23;

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] NORM   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [WIDTH-1:0] QNAN = 32'h7FC00000;

  logic [1:0]                 state;
  logic                       sign_r;
  logic [EXPONENTWIDTH-1:0]   ea_r;
  logic [EXPONENTWIDTH-1:0]   eb_r;
  logic [MANTISSAWIDTH:0]     mb_r;
  logic [MANTISSAWIDTH+2:0]   rem_r;
  logic [MANTISSAWIDTH+1:0]   q_r;
  logic [4:0]                 count_r;

  logic [EXPONENTWIDTH-1:0]   a_exp, b_exp;
  logic [MANTISSAWIDTH-1:0]   a_frac, b_frac;
  logic                       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                       sign_in;

  assign a_exp   = num[30:23];
  assign b_exp   = den[30:23];
  assign a_frac  = num[22:0];
  assign b_frac  = den[22:0];
  // Zero exponent covers both true zero and denormals, which are flushed.
  assign a_zero  = (a_exp == 8'h00);
  assign b_zero  = (b_exp == 8'h00);
  assign a_inf   = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf   = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_nan   = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan   = (b_exp == 8'hFF) && (b_frac != 23'd0);
  assign sign_in = num[31] ^ den[31];

  logic                       rem_ge;
  logic [MANTISSAWIDTH+2:0]   rem_diff;

  assign rem_ge   = (rem_r >= {2'b00, mb_r});
  assign rem_diff = rem_r - {2'b00, mb_r};

  logic signed [9:0]          e_norm;
  logic [MANTISSAWIDTH-1:0]   mant_norm;

  always_comb begin
    e_norm    = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r})
              + (q_r[24] ? 10'sd127 : 10'sd126);
    mant_norm = q_r[24] ? q_r[23:1] : q_r[22:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      rdy     <= 1'b0;
      quo     <= '0;
      sign_r  <= 1'b0;
      ea_r    <= '0;
      eb_r    <= '0;
      mb_r    <= '0;
      rem_r   <= '0;
      q_r     <= '0;
      count_r <= '0;
    end else begin
      case (state)
        LOAD: begin
          sign_r  <= sign_in;
          ea_r    <= a_exp;
          eb_r    <= b_exp;
          mb_r    <= {1'b1, b_frac};
          rem_r   <= {3'b001, a_frac};
          q_r     <= '0;
          count_r <= '0;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            quo   <= QNAN;
            rdy   <= 1'b1;
            state <= DONE;
          end else if (a_inf || b_zero) begin
            quo   <= {sign_in, 8'hFF, 23'd0};
            rdy   <= 1'b1;
            state <= DONE;
          end else if (a_zero || b_inf) begin
            quo   <= {sign_in, 31'd0};
            rdy   <= 1'b1;
            state <= DONE;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (rem_ge) begin
            rem_r <= rem_diff << 1;
            q_r   <= {q_r[23:0], 1'b1};
          end else begin
            rem_r <= rem_r << 1;
            q_r   <= {q_r[23:0], 1'b0};
          end
          count_r <= count_r + 5'd1;
          if (count_r == 5'd24) state <= NORM;
        end
        NORM: begin
          if (e_norm <= 10'sd0)
            quo <= {sign_r, 31'd0};
          else if (e_norm >= 10'sd255)
            quo <= {sign_r, 8'hFF, 23'd0};
          else
            quo <= {sign_r, e_norm[7:0], mant_norm};
          rdy   <= 1'b1;
          state <= DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divide_f32_restoring.sv
// Directed and random bench for divide_f32_restoring with a result/latency scoreboard.
module tb_divide_f32_restoring;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] num = '0;
  logic [31:0] den = '0;
  logic        rdy;
  logic [31:0] quo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  divide_f32_restoring dut (
    .clk(clk),
    .rst(rst),
    .num(num),
    .den(den),
    .rdy(rdy),
    .quo(quo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Truncating reference built from a single wide integer division.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] dividend;
    logic [47:0] qq;
    int          e;
    logic [22:0] mant;
    dividend = {1'b1, a[22:0], 24'd0};
    qq       = dividend / {24'd0, 1'b1, b[22:0]};
    if (qq[24]) begin
      e    = int'(a[30:23]) - int'(b[30:23]) + 127;
      mant = qq[23:1];
    end else begin
      e    = int'(a[30:23]) - int'(b[30:23]) + 126;
      mant = qq[22:0];
    end
    if (e <= 0)        return {a[31] ^ b[31], 31'd0};
    else if (e >= 255) return {a[31] ^ b[31], 8'hFF, 23'd0};
    else               return {a[31] ^ b[31], e[7:0], mant};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int lat);
    @(negedge clk);
    rst = 1'b1;
    num = a;
    den = b;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(expv);
    lat_q.push_back(lat);
  endtask

  task automatic wait_result(input string tag);
    int          edges;
    logic [31:0] e;
    int          l;
    edges = 0;
    while (!rdy && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check({tag, "_lat"}, edges, l);
    check({tag, "_quo"}, quo, e);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] expv, input int lat);
    start_op(a, b, expv, lat);
    wait_result(tag);
  endtask

  initial begin
    #2;
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_quo", quo, 32'd0);

    // 6/2: also verify rdy is still low right after edge 26
    start_op(32'h40C00000, 32'h40000000, 32'h40400000, 27);
    repeat (26) @(posedge clk);
    #1;
    check("six_two_rdy26", {31'd0, rdy}, 32'd0);
    @(posedge clk);
    #1;
    check("six_two_rdy27", {31'd0, rdy}, 32'd1);
    check("six_two_quo", quo, exp_q.pop_front());
    void'(lat_q.pop_front());

    run("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27);
    run("neg_div0",   32'hBF800000, 32'h00000000, 32'hFF800000, 1);
    run("zero_zero",  32'h00000000, 32'h00000000, 32'h7FC00000, 1);
    run("nan_one",    32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1);
    run("inf_inf",    32'hFF800000, 32'h7F800000, 32'h7FC00000, 1);
    run("zero_num",   32'h80000000, 32'h40000000, 32'h80000000, 1);
    run("fin_inf",    32'h40000000, 32'hFF800000, 32'h80000000, 1);
    run("denorm_num", 32'h00000123, 32'h3F800000, 32'h00000000, 1);
    run("overflow",   32'h7F000000, 32'h3E800000, 32'h7F800000, 27);
    run("underflow",  32'h00800000, 32'h7F000000, 32'h00000000, 27);
    run("neg_result", 32'hC1200000, 32'h40A00000, 32'hC0000000, 27);

    // Abort mid-divide, then a fresh operation
    @(negedge clk);
    rst = 1'b1;
    num = 32'h40C00000;
    den = 32'h40000000;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_rdy", {31'd0, rdy}, 32'd0);
    check("abort_quo", quo, 32'd0);
    num = 32'h3F800000;
    den = 32'h40800000;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h3E800000);
    lat_q.push_back(27);
    wait_result("after_abort");

    // Hold: inputs change, result must not
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      num = $urandom;
      den = $urandom;
      @(posedge clk);
      #1;
      check("hold_quo", quo, 32'h3E800000);
      check("hold_rdy", {31'd0, rdy}, 32'd1);
    end

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      if (i % 3 != 0) begin
        a[30:23] = 8'($urandom_range(100, 154));
        b[30:23] = 8'($urandom_range(100, 154));
      end
      run("random", a, b, ref_div(a, b), 27);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
